imem_banked: RTL

- Parametrised successor to the single-macro instruction memory wrapper.
- Backs the instruction address space with NUM_BANKS SRAM banks of configurable width and depth.
- Exposes a valid/ready request channel and a valid/ready response channel with fixed 1-cycle read latency and backpressure.
- Reports misaligned and out-of-range errors.
- Sits between the fetch stage / debug loader and the bank macros.

---
 rtl/imem_pkg.sv | 63 ++++++
 rtl/imem_bank.sv | 47 ++++
 rtl/imem_banked.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared definitions for the banked instruction memory.
//               Provides address-geometry helpers, the packed request and
//               response transport types, and the per-byte even-parity
//               generator. The parity generator is only used when the build
//               defines IMEM_PARITY_EN.
// Revision    : 1.0 - initial banked release
// ============================================================================
package imem_pkg;

    // Upper bounds on the parameter space, used to size the transport types.
    localparam int IMEM_MAX_DW = 64;
    localparam int IMEM_MAX_AW = 64;
    localparam int IMEM_MAX_BE = IMEM_MAX_DW / 8;

    // Number of byte-offset bits within one word.
    function automatic int imem_offs(input int dw);
        return $clog2(dw / 8);
    endfunction

    // Bank-index width. A single bank still gets one bit so that every
    // select signal has a legal, non-zero width.
    function automatic int imem_bank_idx_w(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

    // Row-address width inside one bank.
    function automatic int imem_row_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Packed request as carried by the fetch stage / debug loader. Fields are
    // sized for the widest configuration; narrower builds use the low bits.
    typedef struct packed {
        logic [IMEM_MAX_AW-1:0] addr;
        logic                   we;
        logic [IMEM_MAX_BE-1:0] be;
        logic [IMEM_MAX_DW-1:0] wdata;
    } imem_req_t;

    // Packed response, sized like imem_req_t.
    typedef struct packed {
        logic [IMEM_MAX_DW-1:0] rdata;
        logic                   err;
    } imem_rsp_t;

    // One even-parity bit per byte: bit i makes byte i plus its parity bit
    // carry an even number of ones.
    function automatic logic [IMEM_MAX_BE-1:0] imem_parity_gen(
        input logic [IMEM_MAX_DW-1:0] data
    );
        logic [IMEM_MAX_BE-1:0] par;
        par = '0;
        for (int i = 0; i < IMEM_MAX_BE; i++) begin
            par[i] = ^data[8*i +: 8];
        end
        return par;
    endfunction

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_bank.sv
`default_nettype none
// ============================================================================
// Module      : imem_bank
// Description : One synchronous single-port memory bank. Stands in for the
//               foundry SRAM macro in the ASIC build.
//               - i_ce  : chip enable, active high; no access when low
//               - i_we  : 1 = masked write, 0 = read into the Q register
//               - i_wmask : per-bit write mask, active high
//               - o_q   : read data, held whenever i_ce is low or on a write
//               Contents and Q are not reset, matching the macro.
// Revision    : 1.0 - initial banked release
// ============================================================================
module imem_bank
    import imem_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 1024,
    parameter int ROW_W  = imem_row_w(DEPTH)
) (
    input  wire logic             i_clk,
    input  wire logic             i_ce,
    input  wire logic             i_we,
    input  wire logic [ROW_W-1:0] i_addr,
    input  wire logic [WIDTH-1:0] i_wmask,
    input  wire logic [WIDTH-1:0] i_wdata,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;

    // The write lands at the accepting edge, so a read issued on the very
    // next edge already observes the new contents.
    always_ff @(posedge i_clk) begin
        if (i_ce) begin
            if (i_we) begin
                r_mem[i_addr] <= (r_mem[i_addr] & ~i_wmask) | (i_wdata & i_wmask);
            end else begin
                r_q <= r_mem[i_addr];
            end
        end
    end

    assign o_q = r_q;

endmodule : imem_bank
`default_nettype wire

// File: rtl/imem_banked.sv
`default_nettype none
// ============================================================================
// Module      : imem_banked
// Description : Banked instruction memory. NUM_BANKS contiguous banks of
//               BANK_DEPTH words back the byte address space. Valid/ready
//               request channel, valid/ready response channel, fixed one-cycle
//               read latency, at most one outstanding response.
//               Ports:
//                 i_clk, i_rst_n            clock, async active-low reset
//                 i_req_valid/o_req_ready   request handshake
//                 i_req_addr/we/be/wdata    byte address, write flag,
//                                           byte enables, write data
//                 o_rsp_valid/i_rsp_ready   response handshake
//                 o_rsp_rdata/o_rsp_err     read data (0 for writes and
//                                           address errors), error flag
//               Build option: IMEM_PARITY_EN adds one even-parity bit per
//               byte in every bank; a read parity mismatch raises o_rsp_err
//               while still returning the raw data.
// Revision    : 1.0 - initial banked release
// ============================================================================
module imem_banked
    import imem_pkg::*;
#(
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  wire logic                    i_clk,
    input  wire logic                    i_rst_n,
    input  wire logic                    i_req_valid,
    output logic                         o_req_ready,
    input  wire logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  wire logic                    i_req_we,
    input  wire logic [DATA_WIDTH/8-1:0] i_req_be,
    input  wire logic [DATA_WIDTH-1:0]   i_req_wdata,
    output logic                         o_rsp_valid,
    input  wire logic                    i_rsp_ready,
    output logic      [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                         o_rsp_err
);

    localparam int c_BE_W      = DATA_WIDTH / 8;
    localparam int c_OFFS      = imem_offs(DATA_WIDTH);
    localparam int c_BIDX_W    = imem_bank_idx_w(NUM_BANKS);
    localparam int c_ROW_W     = imem_row_w(BANK_DEPTH);
    // log2 of the total word count; any word index bit at or above this
    // position means the access lies past the last bank.
    localparam int c_LOG_WORDS = $clog2(NUM_BANKS) + $clog2(BANK_DEPTH);
    localparam logic [c_BIDX_W-1:0] c_BANK_MASK = c_BIDX_W'(NUM_BANKS - 1);
`ifdef IMEM_PARITY_EN
    localparam int c_BANK_W    = DATA_WIDTH + c_BE_W;
`else
    localparam int c_BANK_W    = DATA_WIDTH;
`endif

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_word;
    logic [c_ROW_W-1:0]    w_row;
    logic [c_BIDX_W-1:0]   w_bank;
    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic                  w_addr_err;

    assign w_word         = i_req_addr >> c_OFFS;
    assign w_row          = w_word[c_ROW_W-1:0];
    // With a single bank the mask forces the index to zero.
    assign w_bank         = w_word[c_ROW_W +: c_BIDX_W] & c_BANK_MASK;
    assign w_misaligned   = |i_req_addr[c_OFFS-1:0];
    assign w_out_of_range = |(w_word >> c_LOG_WORDS);
    assign w_addr_err     = w_misaligned | w_out_of_range;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic                r_rsp_valid;
    logic                r_addr_err;
    logic                r_we;
    logic [c_BIDX_W-1:0] r_bank;
    logic                w_accept;

    assign o_req_ready = !r_rsp_valid || i_rsp_ready;
    assign w_accept    = i_req_valid && o_req_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_valid <= 1'b0;
            r_addr_err  <= 1'b0;
            r_we        <= 1'b0;
            r_bank      <= '0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_addr_err  <= w_addr_err;
            r_we        <= i_req_we;
            r_bank      <= w_bank;
        end else if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Bank write data and mask
    // ------------------------------------------------------------------
    logic [c_BANK_W-1:0] w_bank_wdata;
    logic [c_BANK_W-1:0] w_bank_wmask;

    always_comb begin
        w_bank_wdata = '0;
        w_bank_wmask = '0;
        w_bank_wdata[DATA_WIDTH-1:0] = i_req_wdata;
        for (int i = 0; i < c_BE_W; i++) begin
            w_bank_wmask[8*i +: 8] = {8{i_req_be[i]}};
`ifdef IMEM_PARITY_EN
            w_bank_wmask[DATA_WIDTH + i] = i_req_be[i];
`endif
        end
`ifdef IMEM_PARITY_EN
        w_bank_wdata[c_BANK_W-1:DATA_WIDTH] =
            c_BE_W'(imem_parity_gen(IMEM_MAX_DW'(i_req_wdata)));
`endif
    end

    // ------------------------------------------------------------------
    // Banks. Chip enables stay low unless a valid, error-free request is
    // accepted this cycle, so Q holds across a stalled response.
    // ------------------------------------------------------------------
    logic [c_BANK_W-1:0] w_bank_q [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic w_ce;
        assign w_ce = w_accept && !w_addr_err && (w_bank == c_BIDX_W'(b));

        imem_bank #(
            .WIDTH (c_BANK_W),
            .DEPTH (BANK_DEPTH),
            .ROW_W (c_ROW_W)
        ) u_bank (
            .i_clk   (i_clk),
            .i_ce    (w_ce),
            .i_we    (i_req_we),
            .i_addr  (w_row),
            .i_wmask (w_bank_wmask),
            .i_wdata (w_bank_wdata),
            .o_q     (w_bank_q[b])
        );
    end

    // ------------------------------------------------------------------
    // Response
    // ------------------------------------------------------------------
    logic [c_BANK_W-1:0]   w_q;
    logic [DATA_WIDTH-1:0] w_q_data;
    logic                  w_rd_ok;
    logic                  w_par_err;

    assign w_q      = w_bank_q[r_bank];
    assign w_q_data = w_q[DATA_WIDTH-1:0];
    // Only a real bank read produces data; writes and address errors give 0.
    assign w_rd_ok  = r_rsp_valid && !r_we && !r_addr_err;

`ifdef IMEM_PARITY_EN
    assign w_par_err = w_rd_ok &&
        (|(w_q[c_BANK_W-1:DATA_WIDTH] ^
           c_BE_W'(imem_parity_gen(IMEM_MAX_DW'(w_q_data)))));
`else
    assign w_par_err = 1'b0;
`endif

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = w_rd_ok ? w_q_data : '0;
    assign o_rsp_err   = r_rsp_valid && (r_addr_err || w_par_err);

endmodule : imem_banked
`default_nettype wire
